// File: rtl/pe_cmd_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pe_cmd_sequencer: loadable command program issuer for pe_array   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pe_cmd_sequencer #(
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int DEPTH            = 16,
  parameter int TIMEOUT          = 255
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          prog_we,
  input  logic [$clog2(DEPTH)-1:0]      prog_addr,
  input  logic [10+2*PRECISION-1:0]     prog_data,
  input  logic [$clog2(DEPTH):0]        prog_len,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [2:0]                    command_to_execute,
  output logic [1:0]                    shift_direction,
  output logic                          image_to_shift,
  output logic [PRECISION-1:0]          a_overwrite,
  output logic [PRECISION-1:0]          b_overwrite,
  output logic                          array_ack,
  input  logic                          ready,
  input  logic [OUTPUT_PRECISION-1:0]   s_out_array,
  output logic [OUTPUT_PRECISION-1:0]   result,
  output logic                          result_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 10 + 2*PRECISION;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  logic [EW-1:0] mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [3:0]    rep_q, rep_d;
  logic [TW-1:0] timer_q, timer_d;

  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic [2:0]                  cmd_q, cmd_d;
  logic [1:0]                  dir_q, dir_d;
  logic                        img_q, img_d;
  logic [PRECISION-1:0]        a_q, a_d;
  logic [PRECISION-1:0]        b_q, b_d;
  logic                        ack_q, ack_d;
  logic [OUTPUT_PRECISION-1:0] result_q, result_d;
  logic                        rv_q, rv_d;

  logic          idle;
  logic          mem_we;
  logic          start_ok;
  logic [AW:0]   len_sel;
  logic [AW-1:0] pc_inc;
  logic [EW-1:0] entry0;
  logic [EW-1:0] entry_cur;
  logic [EW-1:0] entry_nxt;
  logic          timeout_hit;
  logic          last;
  logic          load_en;
  logic [EW-1:0] load_word;

  assign idle      = (state_q == S_IDLE);
  assign mem_we    = prog_we && idle;
  assign start_ok  = start && idle;
  assign len_sel   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign pc_inc    = pc_q + AW'(1);
  // A write landing in the launch cycle must be seen by the first issue.
  assign entry0    = (mem_we && (prog_addr == '0)) ? prog_data : mem_q[0];
  assign entry_cur = mem_q[pc_q];
  assign entry_nxt = mem_q[pc_inc];
  assign timeout_hit = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && (timer_q == TMO);
  assign last      = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      cmd_q    <= 3'b000;
      dir_q    <= '0;
      img_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ack_q    <= 1'b1;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      rep_q    <= rep_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      cmd_q    <= cmd_d;
      dir_q    <= dir_d;
      img_q    <= img_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    rep_d   = rep_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok && (len_sel != '0)) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          len_d   = len_sel;
          rep_d   = entry0[9:6];
          timer_d = '0;
        end
      end
      S_ISSUE: begin
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (!ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timeout_hit) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
          if (ready) state_d = S_ACK;
        end
      end
      S_ACK: begin
        timer_d = '0;
        state_d = S_ISSUE;
        if (rep_q != 4'd0) begin
          rep_d = rep_q - 4'd1;
        end else if (last) begin
          state_d = S_IDLE;
        end else begin
          pc_d  = pc_inc;
          rep_d = entry_nxt[9:6];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    load_word = entry_cur;
    busy_d    = (state_d != S_IDLE);
    done_d    = 1'b0;
    rv_d      = 1'b0;
    error_d   = error_q;
    result_d  = result_q;
    cmd_d     = cmd_q;
    dir_d     = dir_q;
    img_d     = img_q;
    a_d       = a_q;
    b_d       = b_q;
    ack_d     = ack_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          error_d = 1'b0;
          if (len_sel == '0) begin
            done_d = 1'b1;
          end else begin
            load_en   = 1'b1;
            load_word = entry0;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          cmd_d   = 3'b000;
          ack_d   = 1'b1;
        end else if ((state_q == S_WAIT) && ready) begin
          result_d = s_out_array;
          rv_d     = 1'b1;
          cmd_d    = 3'b000;
          ack_d    = 1'b1;
        end
      end
      S_ACK: begin
        if (rep_q != 4'd0) begin
          load_en   = 1'b1;
          load_word = entry_cur;
        end else if (!last) begin
          load_en   = 1'b1;
          load_word = entry_nxt;
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (load_en) begin
      cmd_d = load_word[2:0];
      dir_d = load_word[4:3];
      img_d = load_word[5];
      a_d   = load_word[9+PRECISION:10];
      b_d   = load_word[9+2*PRECISION:10+PRECISION];
      ack_d = 1'b0;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign command_to_execute = cmd_q;
  assign shift_direction    = dir_q;
  assign image_to_shift     = img_q;
  assign a_overwrite        = a_q;
  assign b_overwrite        = b_q;
  assign array_ack          = ack_q;
  assign result             = result_q;
  assign result_valid       = rv_q;

endmodule
`default_nettype wire
